// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port: word-organised SRAM model with
// programmable wait states, write-lane merging, misalignment flagging and perf counters.
package data_mem_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_t;
endpackage

module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 4096,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_enable,
  input  logic            wr_enable,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wr_data,
  input  mem_access_t     wr_access_type,
  output logic            miss,
  output logic [XLEN-1:0] rd_data,
  output logic            err_misaligned,
  output logic [31:0]     stat_accesses,
  output logic [31:0]     stat_stall_cycles
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     acc_q, acc_d;
  logic [31:0]     stall_q, stall_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic            serve;
  logic            misaligned;
  logic            do_write;
  logic [AW-1:0]   idx;
  logic [1:0]      ofs;
  logic [31:0]     rd_word;
  logic [31:0]     merged;
  logic            unused_addr_bits;

  assign req              = rd_enable | wr_enable;
  assign idx              = addr[AW+1:2];
  assign ofs              = addr[1:0];
  assign rd_word          = mem[idx];
  assign unused_addr_bits = ^addr[XLEN-1:AW+2];

  always_comb begin
    misaligned = 1'b0;
    case (wr_access_type)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = ofs[0];
      default:  misaligned = (ofs != 2'b00);
    endcase
  end

  // Merge store lanes into the current word so byte/half writes keep their neighbours.
  always_comb begin
    merged = rd_word;
    case (wr_access_type)
      MEM_BYTE: merged[{ofs, 3'b000} +: 8]      = wr_data[7:0];
      MEM_HALF: merged[{ofs[1], 4'b0000} +: 16] = wr_data[15:0];
      default:  merged                          = wr_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss    = 1'b0;
    serve   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (LATENCY == 0) begin
              serve = 1'b1;
            end else begin
              miss    = 1'b1;
              state_d = BUSY;
              cnt_d   = LAT_M1;
            end
          end
        end
        BUSY: begin
          // A request vanishing mid-access is abandoned without a write or a count.
          if (!req) begin
            state_d = IDLE;
          end else if (cnt_q != 4'd0) begin
            miss  = 1'b1;
            cnt_d = cnt_q - 4'd1;
          end else begin
            serve   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign do_write = serve & wr_enable & ~misaligned;
  assign err_d    = serve & wr_enable & misaligned;
  assign acc_d    = (serve && (acc_q != 32'hFFFF_FFFF)) ? acc_q + 32'd1 : acc_q;
  assign stall_d  = (miss && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      acc_q   <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      stall_q <= stall_d;
    end
  end

  // Array contents deliberately survive reset.
  always @(posedge clk) begin
    if (do_write) begin
      mem[idx] <= merged;
    end
  end

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      mem[i] = 32'd0;
    end
  end

  assign rd_data           = serve ? rd_word : '0;
  assign err_misaligned    = err_q;
  assign stat_accesses     = acc_q;
  assign stat_stall_cycles = stall_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  logic        rst2, rd2, wr2, miss2, err2;
  logic [31:0] addr2, wd2, rdata2, acc2, stl2;
  mem_access_t type2;

  logic        rst0, rd0, wr0, miss0, err0;
  logic [31:0] addr0, wd0, rdata0, acc0, stl0;
  mem_access_t type0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst2), .rd_enable(rd2), .wr_enable(wr2), .addr(addr2),
    .wr_data(wd2), .wr_access_type(type2), .miss(miss2), .rd_data(rdata2),
    .err_misaligned(err2), .stat_accesses(acc2), .stat_stall_cycles(stl2)
  );

  data_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst0), .rd_enable(rd0), .wr_enable(wr0), .addr(addr0),
    .wr_data(wd0), .wr_access_type(type0), .miss(miss0), .rd_data(rdata0),
    .err_misaligned(err0), .stat_accesses(acc0), .stat_stall_cycles(stl0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access on the LATENCY=2 instance, checks stall count and optionally data.
  task automatic access2(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input mem_access_t t,
                         input logic check_rd, input logic [31:0] exp_rd);
    int stalls = 0;
    rd2 = rd; wr2 = wr; addr2 = a; wd2 = d; type2 = t;
    @(negedge clk);
    while (miss2 === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    chk({tag, " stalls"}, 32'(stalls), 32'd2);
    if (check_rd) chk({tag, " rd_data"}, rdata2, exp_rd);
    @(posedge clk); #1;
    rd2 = 1'b0; wr2 = 1'b0;
  endtask

  task automatic access0(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input mem_access_t t,
                         input logic check_rd, input logic [31:0] exp_rd);
    rd0 = rd; wr0 = wr; addr0 = a; wd0 = d; type0 = t;
    @(negedge clk);
    chk({tag, " miss"}, {31'd0, miss0}, 32'd0);
    if (check_rd) chk({tag, " rd_data"}, rdata0, exp_rd);
    @(posedge clk); #1;
    rd0 = 1'b0; wr0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    rst2 = 1'b1; rd2 = 1'b1; wr2 = 1'b0; addr2 = 32'h10; wd2 = '0; type2 = MEM_WORD;
    rst0 = 1'b1; rd0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10; wd0 = '0; type0 = MEM_WORD;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst miss2", {31'd0, miss2}, 32'd0);
    chk("rst rdata2", rdata2, 32'd0);
    chk("rst miss0", {31'd0, miss0}, 32'd0);
    chk("rst rdata0", rdata0, 32'd0);
    @(posedge clk); #1;
    rst2 = 1'b0; rd2 = 1'b0; rst0 = 1'b0; rd0 = 1'b0;
    @(negedge clk);
    chk("post-rst acc2", acc2, 32'd0);
    chk("post-rst stl2", stl2, 32'd0);
    chk("post-rst err2", {31'd0, err2}, 32'd0);
    chk("idle miss2", {31'd0, miss2}, 32'd0);
    @(posedge clk); #1;

    // Basic read with two wait states.
    access2("preload w4", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, MEM_WORD, 1'b0, '0);
    access2("read 0x10", 1'b1, 1'b0, 32'h10, '0, MEM_WORD, 1'b1, 32'hDEADBEEF);
    chk("t1 acc", acc2, 32'd2);
    chk("t1 stl", stl2, 32'd4);

    // Lane merging.
    access2("word 0x20", 1'b0, 1'b1, 32'h20, 32'h11223344, MEM_WORD, 1'b0, '0);
    access2("byte 0x22", 1'b0, 1'b1, 32'h22, 32'h000000AA, MEM_BYTE, 1'b0, '0);
    access2("half 0x20", 1'b0, 1'b1, 32'h20, 32'h0000BEEF, MEM_HALF, 1'b0, '0);
    access2("merge rd", 1'b1, 1'b0, 32'h20, '0, MEM_WORD, 1'b1, 32'h11AABEEF);

    // Misaligned half write is suppressed and flagged once.
    access2("word 0x20b", 1'b0, 1'b1, 32'h20, 32'h12345678, MEM_WORD, 1'b0, '0);
    access2("mis half", 1'b0, 1'b1, 32'h21, 32'h0000FFFF, MEM_HALF, 1'b0, '0);
    chk("mis err pulse", {31'd0, err2}, 32'd1);
    @(posedge clk); #1;
    chk("mis err clear", {31'd0, err2}, 32'd0);
    access2("mis rd", 1'b1, 1'b0, 32'h20, '0, MEM_WORD, 1'b1, 32'h12345678);
    access2("byte 0x21", 1'b0, 1'b1, 32'h21, 32'h0000005A, MEM_BYTE, 1'b0, '0);
    access2("byte1 rd", 1'b1, 1'b0, 32'h20, '0, MEM_WORD, 1'b1, 32'h12345A78);
    chk("byte1 err", {31'd0, err2}, 32'd0);

    // Back-to-back identical reads, request held throughout.
    rd2 = 1'b1; wr2 = 1'b0; addr2 = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("b2b miss %0d", i), {31'd0, miss2}, (i % 3 == 2) ? 32'd0 : 32'd1);
      if (i % 3 == 2) chk($sformatf("b2b rd %0d", i), rdata2, 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    rd2 = 1'b0;
    chk("b2b acc", acc2, 32'd13);
    chk("b2b stl", stl2, 32'd26);

    // Reset aborts a pending write; request dropped during reset.
    access2("preload 0x30", 1'b0, 1'b1, 32'h30, 32'h01020304, MEM_WORD, 1'b0, '0);
    wr2 = 1'b1; addr2 = 32'h30; wd2 = 32'hCAFEF00D; type2 = MEM_WORD;
    @(negedge clk);
    chk("abort miss", {31'd0, miss2}, 32'd1);
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(negedge clk);
    chk("abort rst miss", {31'd0, miss2}, 32'd0);
    chk("abort rst rd", rdata2, 32'd0);
    @(posedge clk); #1;
    rst2 = 1'b0; wr2 = 1'b0;
    @(negedge clk);
    chk("abort acc", acc2, 32'd0);
    chk("abort stl", stl2, 32'd0);
    @(posedge clk); #1;
    access2("abort rd", 1'b1, 1'b0, 32'h30, '0, MEM_WORD, 1'b1, 32'h01020304);

    // Reset with the request held: served as a fresh access afterwards.
    wr2 = 1'b1; addr2 = 32'h30; wd2 = 32'hCAFEF00D; type2 = MEM_WORD;
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(negedge clk);
    chk("held rst miss", {31'd0, miss2}, 32'd0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    s = 0;
    @(negedge clk);
    while (miss2 === 1'b1 && s < 20) begin
      s++;
      @(negedge clk);
    end
    chk("held stalls", 32'(s), 32'd2);
    @(posedge clk); #1;
    wr2 = 1'b0;
    chk("held acc", acc2, 32'd1);
    chk("held stl", stl2, 32'd2);
    access2("held rd", 1'b1, 1'b0, 32'h30, '0, MEM_WORD, 1'b1, 32'hCAFEF00D);

    // Zero-wait-state instance and address aliasing.
    access0("z word", 1'b0, 1'b1, 32'h10, 32'h55AA33CC, MEM_WORD, 1'b0, '0);
    access0("z rd", 1'b1, 1'b0, 32'h10, '0, MEM_WORD, 1'b1, 32'h55AA33CC);
    access0("z alias rd", 1'b1, 1'b0, 32'h4010, '0, MEM_WORD, 1'b1, 32'h55AA33CC);
    access0("z alias byte", 1'b0, 1'b1, 32'h4013, 32'h00000077, MEM_BYTE, 1'b0, '0);
    access0("z rd2", 1'b1, 1'b0, 32'h10, '0, MEM_WORD, 1'b1, 32'h77AA33CC);
    access0("z mis", 1'b0, 1'b1, 32'h13, 32'h00001234, MEM_HALF, 1'b0, '0);
    chk("z err pulse", {31'd0, err0}, 32'd1);
    @(negedge clk);
    chk("z idle rd", rdata0, 32'd0);
    @(posedge clk); #1;
    chk("z err clear", {31'd0, err0}, 32'd0);
    access0("z rd3", 1'b1, 1'b0, 32'h10, '0, MEM_WORD, 1'b1, 32'h77AA33CC);
    chk("z acc", acc0, 32'd7);
    chk("z stl", stl0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
